// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
//   Shared types and constants for the SPI frame receiver.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package spi_pkg;

  // Receiver FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } spi_rx_state_t;

  // SPI mode encoding {CPOL,CPHA}
  localparam int SPI_MODE0 = 0;
  localparam int SPI_MODE1 = 1;
  localparam int SPI_MODE2 = 2;
  localparam int SPI_MODE3 = 3;

  // Modes 0 and 3 sample on the rising SPI clock edge, modes 1 and 2 on the falling edge
  function automatic logic sample_on_rise(input int mode);
    return (mode == SPI_MODE0) || (mode == SPI_MODE3);
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ---------------------------------------------------------------------------
// spi_sync_edge
//   Multi-flop synchroniser for one asynchronous input, followed by a
//   registered rise/fall pulse detector. A pin edge shows up as a one-cycle
//   pulse SYNC_DEPTH+1 clk cycles later.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module spi_sync_edge #(
  parameter int SYNC_DEPTH = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_DEPTH-1:0] chain;
  logic                  prev;

  // Synchroniser chain; the oldest stage is the usable level
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_DEPTH-2:0], din};
    end
  end

  assign sync = chain[SYNC_DEPTH-1];

  // Registered edge detector on the synchronised level
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      prev <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      prev <= sync;
      rise <= sync & ~prev;
      fall <= ~sync & prev;
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_rx_frame.sv
// ---------------------------------------------------------------------------
// spi_rx_frame
//   Oversampling SPI frame receiver. Supports all four SPI modes and either
//   bit order, checks frame length against spi_en framing and offers each
//   good frame on a single-entry valid/ready buffer. Short/long frames pulse
//   frame_err; a good frame arriving at a full buffer pulses overrun.
//   Optional feature: define SPI_RX_PARITY_EN to expect a trailing even
//   parity bit after the payload.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module spi_rx_frame
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 2,
  parameter int DATA_DEPTH = 16,
  parameter int SPI_MODE   = 0,
  parameter int MSB_FIRST  = 1,
  parameter int SYNC_DEPTH = 2
) (
  input  logic                               clk,
  input  logic                               nrst,
  input  logic                               spi_clk,
  input  logic                               spi_en,
  input  logic                               spi_data,
  input  logic                               out_ready,
  output logic                               out_valid,
  output logic [DATA_WIDTH*DATA_DEPTH-1:0]   out_data,
  output logic                               frame_err,
  output logic                               overrun,
  output logic                               busy
);

  localparam int NUM_BITS = DATA_WIDTH * DATA_DEPTH;
`ifdef SPI_RX_PARITY_EN
  localparam int FRAME_BITS = NUM_BITS + 1;
`else
  localparam int FRAME_BITS = NUM_BITS;
`endif
  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);
  localparam logic SAMPLE_RISE = sample_on_rise(SPI_MODE);

  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic en_rise, en_fall, en_level_unused;
  logic data_sync, data_rise_unused, data_fall_unused;

  spi_rx_state_t          state;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_inc;
  logic [FRAME_BITS-1:0]  shreg;
  logic [FRAME_BITS-1:0]  shreg_next;
  logic [NUM_BITS-1:0]    payload;
  logic                   too_long;
  logic                   parity_ok;
  logic                   sample_edge;
  logic                   frame_good;
  logic                   can_load;

  spi_sync_edge #(.SYNC_DEPTH(SYNC_DEPTH)) u_sync_clk (
    .clk  (clk),
    .nrst (nrst),
    .din  (spi_clk),
    .sync (sclk_level_unused),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(.SYNC_DEPTH(SYNC_DEPTH)) u_sync_en (
    .clk  (clk),
    .nrst (nrst),
    .din  (spi_en),
    .sync (en_level_unused),
    .rise (en_rise),
    .fall (en_fall)
  );

  // Data goes through an identical chain so it lines up with the clock edge pulse
  spi_sync_edge #(.SYNC_DEPTH(SYNC_DEPTH)) u_sync_data (
    .clk  (clk),
    .nrst (nrst),
    .din  (spi_data),
    .sync (data_sync),
    .rise (data_rise_unused),
    .fall (data_fall_unused)
  );

  assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
  assign cnt_inc     = cnt + 1'b1;

  // Bit order decides which end of the shift register the new bit enters
  if (MSB_FIRST != 0) begin : g_shift_msb
    assign shreg_next = {shreg[FRAME_BITS-2:0], data_sync};
  end else begin : g_shift_lsb
    assign shreg_next = {data_sync, shreg[FRAME_BITS-1:1]};
  end

`ifdef SPI_RX_PARITY_EN
  logic parity_bit;

  // The parity bit is the last one received: LSB end for MSB-first, MSB end otherwise
  if (MSB_FIRST != 0) begin : g_par_msb
    assign payload    = shreg[FRAME_BITS-1:1];
    assign parity_bit = shreg[0];
  end else begin : g_par_lsb
    assign payload    = shreg[NUM_BITS-1:0];
    assign parity_bit = shreg[FRAME_BITS-1];
  end

  assign parity_ok = ((^payload) == parity_bit);
`else
  assign payload   = shreg;
  assign parity_ok = 1'b1;
`endif

  assign frame_good = ~too_long & parity_ok;
  assign can_load   = ~out_valid | out_ready;

  // Frame FSM, shift register, bit counter and registered output buffer
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      too_long  <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // Consumer handshake; a commit below in the same cycle takes precedence
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (en_rise) begin
            cnt      <= '0;
            shreg    <= '0;
            too_long <= 1'b0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end

        SHIFT: begin
          if (en_fall) begin
            // Frame ended before the expected bit count was reached
            frame_err <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (sample_edge) begin
            shreg <= shreg_next;
            cnt   <= cnt_inc;
            if (cnt_inc == CNT_FULL) begin
              state <= HOLD;
            end
          end
        end

        HOLD: begin
          if (en_fall) begin
            busy  <= 1'b0;
            state <= IDLE;
            if (!frame_good) begin
              frame_err <= 1'b1;
            end else if (can_load) begin
              out_data  <= payload;
              out_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else if (sample_edge) begin
            // Any edge past the full count marks the frame as too long
            too_long <= 1'b1;
            if (cnt != CNT_SAT) begin
              cnt <= cnt_inc;
            end
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/spi_rx_frame.md
# spi_rx_frame

Parametrised SPI frame receiver, successor to the fixed-format SPI input block. It oversamples `spi_clk`, `spi_en` and `spi_data` on the system clock and supports all four SPI modes and either bit order. It validates frame length against `spi_en` framing and presents each good frame on a valid/ready output buffer. Short, long and overrun frames are reported rather than silently passed downstream.

## Interface
- `DATA_WIDTH`, 2: bits per element.
- `DATA_DEPTH`, 16: elements per frame; `NUM_BITS = DATA_WIDTH*DATA_DEPTH`.
- `SPI_MODE`, 0: 0..3, {CPOL,CPHA}.
- `MSB_FIRST`, 1: 1 = first received bit lands in `out_data[NUM_BITS-1]`; 0 = lands in `out_data[0]`.
- `SYNC_DEPTH`, 2: synchroniser flops per async input, ≥2.
- `clk` in 1: system clock.
- `nrst` in 1: reset, asynchronous, active-low.
- `spi_clk` in 1: async SPI clock.
- `spi_en` in 1: async frame enable, active-high.
- `spi_data` in 1: async serial data.
- `out_ready` in 1: consumer accepts frame.
- `out_valid` out 1: frame buffer holds a good frame.
- `out_data` out NUM_BITS: frame payload, stable while `out_valid`.
- `frame_err` out 1: one-cycle pulse, frame ended with bit count ≠ expected.
- `overrun` out 1: one-cycle pulse, good frame dropped because buffer full.
- `busy` out 1: high in SHIFT or HOLD.

## Operation
- Sample edge: rising for modes 0 and 3, falling for modes 1 and 2, detected on synchronised `spi_clk`.
- `spi_data` is synchronised with the same depth so data aligns with the detected edge.
- Expected bit count `FRAME_BITS = NUM_BITS` (+1 with parity, see Configuration). Counter width is `$clog2(FRAME_BITS+2)` and saturates at `FRAME_BITS+1`.
- FSM states:
  - IDLE: sample edges ignored. Synced `spi_en` rise clears counter and shift register, then goes to SHIFT.
  - SHIFT: each sample edge shifts one bit in and increments the counter. Counter = FRAME_BITS goes to HOLD. Synced `spi_en` fall goes to IDLE and pulses `frame_err`.
  - HOLD: a further sample edge sets internal `too_long`. Synced `spi_en` fall goes to IDLE and either commits (`too_long`=0) or pulses `frame_err` (`too_long`=1).
- Commit rules:
  - Buffer empty, or `out_valid & out_ready` in the same cycle: load `out_data`, `out_valid`=1.
  - Otherwise: pulse `overrun`, keep the old frame.
- Handshake: a transfer occurs when `out_valid & out_ready` at a clk edge. `out_valid` falls next cycle unless a commit coincides.
- `spi_en` rise while in SHIFT or HOLD is impossible without a prior fall. Synced rise and fall in the same cycle cannot occur.
- Reset mid-frame: all state discarded. FSM=IDLE, counter=0, shift register=0.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `frame_err`=0, `overrun`=0, `busy`=0.
- Pin edge to internal edge pulse: SYNC_DEPTH+1 clk cycles.
- `spi_en` pin fall to `out_valid` high: SYNC_DEPTH+2 clk cycles.
- `frame_err` and `overrun` assert in the same cycle the commit would have occurred.
- `spi_clk` high and low phases each ≥3 clk periods. Last sample edge to `spi_en` fall ≥2 clk periods.
- `out_data` changes only on commit.

## Configuration
- `SPI_RX_PARITY_EN` defined:
  - `FRAME_BITS = NUM_BITS+1`; last bit is even parity over the payload.
  - A parity mismatch at commit drops the frame and pulses `frame_err`.
  - Parity bit not stored in `out_data`.
- `SPI_RX_PARITY_EN` undefined: `FRAME_BITS = NUM_BITS`; no parity logic.

## Structure
- Package `spi_pkg`: `spi_rx_state_t` enum {IDLE, SHIFT, HOLD} and SPI mode constants `SPI_MODE0..3`.
- Sub-module `spi_sync_edge`: SYNC_DEPTH synchroniser plus rise/fall pulse detector.
  - One instance each for `spi_clk` and `spi_en`.
  - `spi_data` uses the synchroniser only.

## Test plan
- Mode 0, MSB_FIRST=1, 32 bits 0xA5A50F0F -> `out_valid`=1 with `out_data`=0xA5A50F0F SYNC_DEPTH+2 cycles after `spi_en` fall. `out_ready`=1 -> `out_valid`=0 next cycle.
- Mode 1, MSB_FIRST=0, 0x12345678 shifted LSB first on falling edges -> `out_data`=0x12345678.
- 31-bit frame, then 33-bit frame -> `frame_err` pulses once each. `out_valid` stays 0.
- Two good frames 0x1 then 0x2 with `out_ready`=0 -> `out_data`=0x1 held, `overrun` pulses at second commit. With `out_ready`=1 at second commit -> `out_data`=0x2, no overrun.
- `nrst` low after 10 bits, released, then full frame 0xFFFFFFFF -> no stale bits, `out_data`=0xFFFFFFFF, no `frame_err`.
- `SPI_RX_PARITY_EN`: payload 0x00000001 with parity 1 -> accepted. Parity 0 -> `frame_err` pulse, `out_valid` stays 0.
